// File: rtl/relay_mode_sched.sv
// Relay turn-around scheduler: watches the decoded relay bitstream and sequences
// the hi-simulate modulation mode through IDLE/LISTEN/PRE/TX/GUARD.
module relay_mode_sched #(
  parameter int GUARD_TICKS = 8,
  parameter int PRE_TIMEOUT = 64,
  parameter int TX_TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  hi_simulate_mod_type,
  input  logic        bit_tick,
  input  logic        bit_in,
  input  logic        activity,
  output logic [2:0]  mod_type,
  output logic        tx_active,
  output logic        frame_done,
  output logic [15:0] frame_bits,
  output logic        timeout_err,
  output logic [2:0]  state_dbg_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LISTEN = 3'd1,
    S_PRE    = 3'd2,
    S_TX     = 3'd3,
    S_GUARD  = 3'd4
  } state_t;

  localparam logic [2:0]  MODE_READER = 3'b101;
  localparam logic [2:0]  MODE_TAG    = 3'b110;
  localparam logic [15:0] GUARD_LIM   = 16'(GUARD_TICKS);
  localparam logic [15:0] PRE_LIM     = 16'(PRE_TIMEOUT);
  localparam logic [15:0] TX_LIM      = 16'(TX_TIMEOUT);

  state_t      state_q, state_d;
  logic [2:0]  mode_q;
  logic [11:0] sh_q, sh_d;
  logic [15:0] tc_q, tc_d;
  logic [15:0] frame_bits_q, frame_bits_d;
  logic        timeout_err_q, timeout_err_d;
  logic        done_pend_q, done_pend_d;
  logic        frame_done_q;
  logic [2:0]  mod_type_q, mod_type_d;
  logic        tx_active_q;

  logic        mode_valid, prev_valid, reader, mode_change;
  logic [11:0] sh_shift;
  logic [3:0]  nib;
  logic        sof, eof, tx_to;
  logic [15:0] tc_inc, fb_inc;

  always_comb begin
    mode_valid  = (hi_simulate_mod_type == MODE_READER) || (hi_simulate_mod_type == MODE_TAG);
    prev_valid  = (mode_q == MODE_READER) || (mode_q == MODE_TAG);
    reader      = (hi_simulate_mod_type == MODE_READER);
    // Only a switch between the two valid modes counts as a mode change.
    mode_change = mode_valid && prev_valid && (hi_simulate_mod_type != mode_q);
    sh_shift    = {sh_q[10:0], bit_in};
    nib         = reader ? 4'hc : 4'hf;
    sof         = bit_tick && (sh_shift == {8'h00, nib});
    tc_inc      = tc_q + 16'd1;
    fb_inc      = (frame_bits_q == 16'hFFFF) ? frame_bits_q : frame_bits_q + 16'd1;
    eof         = bit_tick && (sh_shift[7:0] == 8'h00) && (fb_inc >= 16'd8) && (fb_inc[1:0] == 2'b00);
    tx_to       = bit_tick && (tc_inc >= TX_LIM);
  end

  always_comb begin
    state_d       = state_q;
    sh_d          = bit_tick ? sh_shift : sh_q;
    tc_d          = bit_tick ? tc_inc : tc_q;
    frame_bits_d  = frame_bits_q;
    timeout_err_d = timeout_err_q;
    done_pend_d   = 1'b0;

    if (!mode_valid) begin
      state_d = S_IDLE;
    end else if (mode_change) begin
      state_d       = S_IDLE;
      timeout_err_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_LISTEN;
        S_LISTEN: begin
          if (sof) begin
            state_d      = S_TX;
            frame_bits_d = 16'd1;
          end else if (activity && reader) begin
            state_d = S_PRE;
          end
        end
        S_PRE: begin
          if (sof) begin
            state_d      = S_TX;
            frame_bits_d = 16'd1;
          end else if (bit_tick && (tc_inc >= PRE_LIM)) begin
            state_d = S_LISTEN;
          end
        end
        S_TX: begin
          if (bit_tick) begin
            frame_bits_d = fb_inc;
            if (eof) begin
              state_d     = S_GUARD;
              done_pend_d = 1'b1;
            end else if (tx_to) begin
              state_d       = S_GUARD;
              timeout_err_d = 1'b1;
              done_pend_d   = 1'b1;
            end
          end
        end
        S_GUARD: begin
          if (bit_tick && (tc_inc >= GUARD_LIM)) state_d = S_LISTEN;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d != state_q) tc_d = 16'd0;
    if (state_d == S_IDLE)  sh_d = 12'd0;

    case (state_d)
      S_LISTEN, S_GUARD: mod_type_d = reader ? 3'b011 : 3'b001;
      S_TX:              mod_type_d = reader ? 3'b100 : 3'b010;
      default:           mod_type_d = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      mode_q        <= 3'b000;
      sh_q          <= 12'd0;
      tc_q          <= 16'd0;
      frame_bits_q  <= 16'd0;
      timeout_err_q <= 1'b0;
      done_pend_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      mod_type_q    <= 3'b000;
      tx_active_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= hi_simulate_mod_type;
      sh_q          <= sh_d;
      tc_q          <= tc_d;
      frame_bits_q  <= frame_bits_d;
      timeout_err_q <= timeout_err_d;
      // frame_done lags the TX exit by one extra cycle.
      done_pend_q   <= done_pend_d;
      frame_done_q  <= done_pend_q;
      mod_type_q    <= mod_type_d;
      tx_active_q   <= (state_d == S_TX);
    end
  end

  assign mod_type    = mod_type_q;
  assign tx_active   = tx_active_q;
  assign frame_done  = frame_done_q;
  assign frame_bits  = frame_bits_q;
  assign timeout_err = timeout_err_q;
  assign state_dbg_o = state_q;

endmodule
